// File: rtl/keystream_sequencer.sv
// rtl/keystream_sequencer.sv - frame sequencer for the float-to-integer keystream extractor
// Optional KSEQ_STALL_CNT_EN adds the stall_cycles counter output.
module keystream_sequencer #(
    parameter int PIPE_DEPTH = 5,
    parameter int CNT_W      = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_num_words,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_val1,
    input  logic [31:0]      in_val2,
    input  logic [31:0]      in_val3,
    output logic [31:0]      ext_val1,
    output logic [31:0]      ext_val2,
    output logic [31:0]      ext_val3,
    output logic             ext_enable,
    input  logic [22:0]      ext_ex1,
    input  logic [22:0]      ext_ex2,
    input  logic [22:0]      ext_ex3,
    output logic             ks_valid,
    input  logic             ks_ready,
    output logic [22:0]      ks1,
    output logic [22:0]      ks2,
    output logic [22:0]      ks3,
    output logic             busy,
    output logic             frame_done
`ifdef KSEQ_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    localparam int RUN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(PIPE_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IN,
        S_RUN,
        S_CAPTURE,
        S_HOLD
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [RUN_W-1:0] run_cnt;
    logic [CNT_W-1:0] remaining;

    logic load_in;
    logic cap_ks;
    logic load_rem;
    logic dec_rem;
    logic clr_rem;
    logic done_next;

    // Handshake and enable outputs are pure state decodes, so none of them
    // depends combinationally on in_valid or ks_ready.
    assign in_ready   = (state == S_WAIT_IN);
    assign ext_enable = (state == S_RUN);
    assign ks_valid   = (state == S_HOLD);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load_in    = 1'b0;
        cap_ks     = 1'b0;
        load_rem   = 1'b0;
        dec_rem    = 1'b0;
        clr_rem    = 1'b0;
        done_next  = 1'b0;
        if (abort && (state != S_IDLE)) begin
            state_next = S_IDLE;
            clr_rem    = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_num_words != '0) begin
                            load_rem   = 1'b1;
                            state_next = S_WAIT_IN;
                        end else begin
                            done_next = 1'b1;
                        end
                    end
                end
                S_WAIT_IN: begin
                    if (in_valid) begin
                        load_in    = 1'b1;
                        state_next = S_RUN;
                    end
                end
                S_RUN: begin
                    if (run_cnt == RUN_LAST) begin
                        state_next = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    cap_ks     = 1'b1;
                    state_next = S_HOLD;
                end
                S_HOLD: begin
                    if (ks_ready) begin
                        dec_rem = 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            state_next = S_IDLE;
                            done_next  = 1'b1;
                        end else begin
                            state_next = S_WAIT_IN;
                        end
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext_val1   <= '0;
            ext_val2   <= '0;
            ext_val3   <= '0;
            ks1        <= '0;
            ks2        <= '0;
            ks3        <= '0;
            run_cnt    <= '0;
            remaining  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= done_next;
            if (load_in) begin
                ext_val1 <= in_val1;
                ext_val2 <= in_val2;
                ext_val3 <= in_val3;
                run_cnt  <= '0;
            end else if (state == S_RUN) begin
                run_cnt <= run_cnt + RUN_W'(1);
            end
            // The pipeline is frozen outside RUN, so its outputs are a clean flush here.
            if (cap_ks) begin
                ks1 <= ext_ex1;
                ks2 <= ext_ex2;
                ks3 <= ext_ex3;
            end
            if (clr_rem) begin
                remaining <= '0;
            end else if (load_rem) begin
                remaining <= cfg_num_words;
            end else if (dec_rem && (remaining != '0)) begin
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

`ifdef KSEQ_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if ((state == S_IDLE) && start) begin
            stall_cycles <= '0;
        end else if (((state == S_WAIT_IN) && !in_valid) ||
                     ((state == S_HOLD) && !ks_ready)) begin
            if (stall_cycles != 32'hFFFF_FFFF) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
